// File: rtl/gpio_irq_controller.sv
// GPIO interrupt front end: sync, optional debounce, edge/level detect, sticky pending.
// Define GPIO_IRQ_DEBOUNCE_EN to build the per-channel debounce filter.
module gpio_irq_controller #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] ier,
  input  logic [WIDTH-1:0] rier,
  input  logic [WIDTH-1:0] fier,
  input  logic [WIDTH-1:0] hier,
  input  logic [WIDTH-1:0] lier,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] io_filtered,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 ||
      DEBOUNCE_CYCLES < 1) begin : g_param_chk
    $error("gpio_irq_controller: illegal parameters");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] lvl_evt;
  logic [WIDTH-1:0] pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_out[i] != filt_q[i]) begin
          if (cnt[i] == CNT_MAX) begin
            filt_q[i] <= sync_out[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_out;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= filt;
  end

  assign rise     = filt & ~prev;
  assign fall     = ~filt & prev;
  assign edge_evt = ier & ((rier & rise) | (fier & fall));
  assign lvl_evt  = ier & ((hier & filt) | (lier & ~filt));

  // Edges beat a same-cycle clear; a held level re-arms one cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= edge_evt | ((lvl_evt | pend_q) & ~clr);
  end

  assign io_filtered = filt;
  assign pending     = pend_q;
  assign irq         = |(pend_q & ier);

endmodule

// File: tb/tb_gpio_irq_controller.sv
// Directed self-checking bench for gpio_irq_controller.
// Honours GPIO_IRQ_DEBOUNCE_EN for latency and the debounce cases.
module tb_gpio_irq_controller;

`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  localparam int LAT = 2 + DEB + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] io_in, ier, rier, fier, hier, lier, clr;
  logic [31:0] io_filtered, pending;
  logic        irq;

  logic [7:0]  io8, ier8, rier8, clr8, zero8;
  logic [7:0]  filt8, pend8;
  logic        irq8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gpio_irq_controller u_dut (
    .clk         (clk),
    .rst         (rst),
    .io_in       (io_in),
    .ier         (ier),
    .rier        (rier),
    .fier        (fier),
    .hier        (hier),
    .lier        (lier),
    .clr         (clr),
    .io_filtered (io_filtered),
    .pending     (pending),
    .irq         (irq)
  );

  gpio_irq_controller #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .io_in       (io8),
    .ier         (ier8),
    .rier        (rier8),
    .fier        (zero8),
    .hier        (zero8),
    .lier        (zero8),
    .clr         (clr8),
    .io_filtered (filt8),
    .pending     (pend8),
    .irq         (irq8)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    io_in = '0; ier = '0; rier = '0; fier = '0;
    hier  = '0; lier = '0; clr = '0;
    io8   = '0; ier8 = '0; rier8 = '0; clr8 = '0; zero8 = '0;
    tick(2);
    chk("rst_pending", pending, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h1 & 32'h0);
    chk("rst_filt", io_filtered, 32'h0);
    rst = 1'b0;
    tick(2);

    // rising edge on channel 3
    ier[3] = 1'b1; rier[3] = 1'b1; io_in[3] = 1'b1;
    tick(LAT - 1);
    chk("r3_filt", {31'b0, io_filtered[3]}, 32'h1);
    chk("r3_early", {31'b0, pending[3]}, 32'h0);
    tick(1);
    chk("r3_pend", {31'b0, pending[3]}, 32'h1);
    chk("r3_irq", {31'b0, irq}, 32'h1);
    clr[3] = 1'b1;
    tick(1);
    clr[3] = 1'b0;
    chk("r3_clr", {31'b0, pending[3]}, 32'h0);
    chk("r3_clr_irq", {31'b0, irq}, 32'h0);
    tick(2);
    chk("r3_stay", {31'b0, pending[3]}, 32'h0);
    ier[3] = 1'b0; rier[3] = 1'b0; io_in[3] = 1'b0;
    tick(LAT + 1);

    // both edges and masking on channel 0
    ier[0] = 1'b1; rier[0] = 1'b1; fier[0] = 1'b1; io_in[0] = 1'b1;
    tick(LAT);
    chk("b0_rise", {31'b0, pending[0]}, 32'h1);
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    chk("b0_clr", {31'b0, pending[0]}, 32'h0);
    io_in[0] = 1'b0;
    tick(LAT);
    chk("b0_fall", {31'b0, pending[0]}, 32'h1);
    ier[0] = 1'b0;
    #1;
    chk("b0_mask_irq", {31'b0, irq}, 32'h0);
    tick(2);
    chk("b0_mask_pend", {31'b0, pending[0]}, 32'h1);
    ier[0] = 1'b1;
    #1;
    chk("b0_unmask_irq", {31'b0, irq}, 32'h1);
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    ier[0] = 1'b0; rier[0] = 1'b0; fier[0] = 1'b0;
    chk("b0_final", pending, 32'h0);

    // level event versus clear on channel 7
    ier[7] = 1'b1; hier[7] = 1'b1; io_in[7] = 1'b1;
    tick(LAT);
    chk("l7_set", {31'b0, pending[7]}, 32'h1);
    clr[7] = 1'b1;
    tick(1);
    clr[7] = 1'b0;
    chk("l7_clr", {31'b0, pending[7]}, 32'h0);
    tick(1);
    chk("l7_reset", {31'b0, pending[7]}, 32'h1);

    // clear coinciding with a rise on channel 9
    ier[9] = 1'b1; rier[9] = 1'b1; io_in[9] = 1'b1;
    tick(LAT - 1);
    clr[9] = 1'b1;
    tick(1);
    clr[9] = 1'b0;
    chk("e9_set_wins", {31'b0, pending[9]}, 32'h1);

    // 8-channel instance, all channels at once
    ier8 = 8'hFF; rier8 = 8'hFF; io8 = 8'hFF;
    tick(LAT - 1);
    chk("w8_early", {24'b0, pend8}, 32'h0);
    tick(1);
    chk("w8_all", {24'b0, pend8}, 32'hFF);
    clr8 = 8'h0F;
    tick(1);
    clr8 = 8'h00;
    chk("w8_clr", {24'b0, pend8}, 32'hF0);
    chk("w8_irq", {31'b0, irq8}, 32'h1);

`ifdef GPIO_IRQ_DEBOUNCE_EN
    // 3-cycle glitch then stable high on channel 5
    ier[5] = 1'b1; rier[5] = 1'b1; io_in[5] = 1'b1;
    tick(3);
    io_in[5] = 1'b0;
    tick(8);
    chk("d5_glitch_filt", {31'b0, io_filtered[5]}, 32'h0);
    chk("d5_glitch_pend", {31'b0, pending[5]}, 32'h0);
    io_in[5] = 1'b1;
    tick(5);
    chk("d5_early", {31'b0, io_filtered[5]}, 32'h0);
    tick(1);
    chk("d5_filt", {31'b0, io_filtered[5]}, 32'h1);
    chk("d5_pend_early", {31'b0, pending[5]}, 32'h0);
    tick(1);
    chk("d5_pend", {31'b0, pending[5]}, 32'h1);
`endif

    // asynchronous reset mid-operation
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_pend", pending, 32'h0);
    chk("arst_irq", {31'b0, irq}, 32'h0);
    chk("arst_filt", io_filtered, 32'h0);
    chk("arst_pend8", {24'b0, pend8}, 32'h0);
    io_in = '0;
    io8   = '0;
    tick(2);
    rst = 1'b0;
    tick(LAT + 3);
    chk("post_rst_pend", pending, 32'h0);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);
    chk("post_rst_pend8", {24'b0, pend8}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
